// File: rtl/sm3_pkg.sv
// Shared SM3 message-expansion definitions: block and round counts, FSM
// state encoding, and the rotate/P1 helpers used by the W_(j+16) generator.
package sm3_pkg;

  localparam int unsigned SM3_WORD_W          = 32;
  localparam int unsigned SM3_BLK_WORD_NUM    = 16;
  localparam int unsigned SM3_EXPND_ROUND_NUM = 64;
  localparam int unsigned SM3_LD_CNT_W        = $clog2(SM3_BLK_WORD_NUM);
  localparam int unsigned SM3_RND_CNT_W       = $clog2(SM3_EXPND_ROUND_NUM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EXPND = 2'd2
  } sm3_expnd_st_e;

  function automatic logic [SM3_WORD_W-1:0] sm3_rotl(
    input logic [SM3_WORD_W-1:0] x,
    input int unsigned           n
  );
    return (x << n) | (x >> (SM3_WORD_W - n));
  endfunction

  function automatic logic [SM3_WORD_W-1:0] sm3_p1(
    input logic [SM3_WORD_W-1:0] x
  );
    return x ^ sm3_rotl(x, 15) ^ sm3_rotl(x, 23);
  endfunction

endpackage

// File: rtl/sm3_expnd_core_if.sv
// Pad-stage input and compression-stage output signals of the SM3 message
// expansion core. master = pad/compression side, slave = expansion core.
interface sm3_expnd_core_if;
  import sm3_pkg::*;

  logic [SM3_WORD_W-1:0]    pad_inpt_d_i;
  logic                     pad_inpt_vld_i;
  logic                     pad_inpt_lst_i;
  logic                     pad_otpt_ena_o;
  logic                     expnd_otpt_ena_i;
  logic [SM3_WORD_W-1:0]    expnd_otpt_wj_o;
  logic [SM3_WORD_W-1:0]    expnd_otpt_wjj_o;
  logic [SM3_RND_CNT_W-1:0] expnd_otpt_idx_o;
  logic                     expnd_otpt_vld_o;
  logic                     expnd_otpt_lst_o;

  modport master (
    output pad_inpt_d_i, pad_inpt_vld_i, pad_inpt_lst_i, expnd_otpt_ena_i,
    input  pad_otpt_ena_o, expnd_otpt_wj_o, expnd_otpt_wjj_o,
           expnd_otpt_idx_o, expnd_otpt_vld_o, expnd_otpt_lst_o
  );

  modport slave (
    input  pad_inpt_d_i, pad_inpt_vld_i, pad_inpt_lst_i, expnd_otpt_ena_i,
    output pad_otpt_ena_o, expnd_otpt_wj_o, expnd_otpt_wjj_o,
           expnd_otpt_idx_o, expnd_otpt_vld_o, expnd_otpt_lst_o
  );

endinterface

// File: rtl/sm3_expnd_wgen.sv
// Combinational SM3 expansion word generator:
// W_(j+16) = P1(W_j ^ W_(j+7) ^ ROTL(W_(j+13),15)) ^ ROTL(W_(j+3),7) ^ W_(j+10)
module sm3_expnd_wgen
  import sm3_pkg::*;
(
  input  logic [SM3_WORD_W-1:0] w0,
  input  logic [SM3_WORD_W-1:0] w3,
  input  logic [SM3_WORD_W-1:0] w7,
  input  logic [SM3_WORD_W-1:0] w10,
  input  logic [SM3_WORD_W-1:0] w13,
  output logic [SM3_WORD_W-1:0] w16
);

  // next expansion word from the five taps of the sliding window
  always_comb begin
    w16 = sm3_p1(w0 ^ w7 ^ sm3_rotl(w13, 15)) ^ sm3_rotl(w3, 7) ^ w10;
  end

endmodule

// File: rtl/sm3_expnd_core.sv
// SM3 message expansion core: loads a 16-word block from the pad stage into a
// sliding window, then emits W_j / W'_j for j = 0..63 to the compression stage.
// Optional macro SM3_EXPND_OTPT_PIPE_EN adds a registered output stage.
module sm3_expnd_core
  import sm3_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  sm3_expnd_core_if.slave io
);

  localparam logic [SM3_LD_CNT_W-1:0]  LD_LAST  = SM3_LD_CNT_W'(SM3_BLK_WORD_NUM - 1);
  localparam logic [SM3_RND_CNT_W-1:0] RND_LAST = SM3_RND_CNT_W'(SM3_EXPND_ROUND_NUM - 1);

  sm3_expnd_st_e st_q, st_d;

  logic [SM3_LD_CNT_W-1:0]                         ld_cnt_q;
  logic [SM3_RND_CNT_W-1:0]                        rnd_cnt_q;
  logic                                            blk_lst_q;
  logic [SM3_BLK_WORD_NUM-1:0][SM3_WORD_W-1:0]     win_q;
  logic [SM3_WORD_W-1:0]                           w_new;

  logic                     pad_ena;
  logic                     pad_acc;
  logic                     core_vld;
  logic                     take;
  logic                     xfer;
  logic [SM3_WORD_W-1:0]    c_wj;
  logic [SM3_WORD_W-1:0]    c_wjj;
  logic [SM3_RND_CNT_W-1:0] c_idx;
  logic                     c_lst;

  assign pad_ena  = (st_q != ST_EXPND);
  assign pad_acc  = io.pad_inpt_vld_i & pad_ena;
  assign core_vld = (st_q == ST_EXPND);
  assign xfer     = core_vld & take;

  sm3_expnd_wgen u_wgen (
    .w0  (win_q[0]),
    .w3  (win_q[3]),
    .w7  (win_q[7]),
    .w10 (win_q[10]),
    .w13 (win_q[13]),
    .w16 (w_new)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  // next-state: load 16 words, then expand 64 rounds, then back to idle
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE:  if (pad_acc) st_d = ST_LOAD;
      ST_LOAD:  if (pad_acc && (ld_cnt_q == LD_LAST)) st_d = ST_EXPND;
      ST_EXPND: if (xfer && (rnd_cnt_q == RND_LAST)) st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  // load/round counters and the block-last flag taken from the 16th word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q  <= '0;
      rnd_cnt_q <= '0;
      blk_lst_q <= 1'b0;
    end else begin
      if (pad_acc) begin
        ld_cnt_q <= (ld_cnt_q == LD_LAST) ? '0 : ld_cnt_q + 1'b1;
        if (ld_cnt_q == LD_LAST) blk_lst_q <= io.pad_inpt_lst_i;
      end
      if (xfer) rnd_cnt_q <= (rnd_cnt_q == RND_LAST) ? '0 : rnd_cnt_q + 1'b1;
    end
  end

  // window: fill by load index, then slide by one word per output transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       win_q <= '0;
    else if (pad_acc) win_q[ld_cnt_q] <= io.pad_inpt_d_i;
    else if (xfer)    win_q <= {w_new, win_q[SM3_BLK_WORD_NUM-1:1]};
  end

  // round outputs straight from the window head, forced to zero outside EXPND
  always_comb begin
    c_wj  = '0;
    c_wjj = '0;
    c_idx = '0;
    c_lst = 1'b0;
    if (core_vld) begin
      c_wj  = win_q[0];
      c_wjj = win_q[0] ^ win_q[4];
      c_idx = rnd_cnt_q;
      c_lst = (rnd_cnt_q == RND_LAST) & blk_lst_q;
    end
  end

  assign io.pad_otpt_ena_o = pad_ena;

`ifdef SM3_EXPND_OTPT_PIPE_EN
  logic                     o_vld_q;
  logic [SM3_WORD_W-1:0]    o_wj_q;
  logic [SM3_WORD_W-1:0]    o_wjj_q;
  logic [SM3_RND_CNT_W-1:0] o_idx_q;
  logic                     o_lst_q;

  // the core advances only when the output stage is empty or draining, so a
  // stalled word sits in the stage while the window holds the next one
  assign take = ~o_vld_q | io.expnd_otpt_ena_i;

  // output register stage, refilled whenever it can hand its word on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld_q <= 1'b0;
      o_wj_q  <= '0;
      o_wjj_q <= '0;
      o_idx_q <= '0;
      o_lst_q <= 1'b0;
    end else if (take) begin
      o_vld_q <= core_vld;
      o_wj_q  <= c_wj;
      o_wjj_q <= c_wjj;
      o_idx_q <= c_idx;
      o_lst_q <= c_lst;
    end
  end

  assign io.expnd_otpt_vld_o = o_vld_q;
  assign io.expnd_otpt_wj_o  = o_wj_q;
  assign io.expnd_otpt_wjj_o = o_wjj_q;
  assign io.expnd_otpt_idx_o = o_idx_q;
  assign io.expnd_otpt_lst_o = o_lst_q;
`else
  assign take = io.expnd_otpt_ena_i;

  assign io.expnd_otpt_vld_o = core_vld;
  assign io.expnd_otpt_wj_o  = c_wj;
  assign io.expnd_otpt_wjj_o = c_wjj;
  assign io.expnd_otpt_idx_o = c_idx;
  assign io.expnd_otpt_lst_o = c_lst;
`endif

endmodule
